axi_pattern_writer: RTL and testbench

PL-side AXI4 write master that fills a target memory (AXI BRAM behind M_AXI_LPD, or DDR via NoC) with a known 128-bit pattern, then raises an interrupt. It is the hardware stage upstream of the CIPS R5/A72 read-back checks and replaces the MicroBlaze software fill. It issues INCR bursts, never crosses a 4 KB boundary, and keeps one burst outstanding at a time.

---
 rtl/axi_pattern_writer_pkg.sv | 29 ++
 rtl/axi_burst_len_calc.sv | 28 ++
 rtl/axi_pattern_writer.sv | 204 ++++++++++++++++++++
 tb/tb_axi_pattern_writer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pattern_writer_pkg.sv
// rtl/axi_pattern_writer_pkg.sv - shared constants and beat-data helper for the pattern writer
package axi_pattern_writer_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0]   BURST_INCR      = 2'b01;
  localparam logic [1:0]   RESP_OKAY       = 2'b00;
  localparam logic [2:0]   AXSIZE_16B      = 3'b100;
  localparam logic [3:0]   AXCACHE_BUF     = 4'b0011;
  localparam logic [127:0] PATTERN_DEFAULT = 128'hDEADBEAF12345678AABBCCDD11223344;

  // Address mode puts the byte address of each 32-bit lane into that lane.
  function automatic logic [127:0] beat_data(input logic [31:0] addr, input logic mode,
                                             input logic [127:0] pattern);
    logic [127:0] d;
    d = pattern;
    if (mode) begin
      for (int k = 0; k < 4; k++) begin
        d[32*k +: 32] = addr + 32'(4 * k);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// rtl/axi_burst_len_calc.sv - burst length limited by remaining beats, MAX_BURST and the 4 KB page
module axi_burst_len_calc #(
  parameter int MAX_BURST = 16
) (
  input  logic [11:0] i_addr_lo,
  input  logic [15:0] i_remaining,
  output logic [7:0]  o_awlen,
  output logic [8:0]  o_beats
);

  logic [8:0] w_room;
  logic [8:0] w_beats;

  always_comb begin
    w_room  = 9'((13'd4096 - {1'b0, i_addr_lo}) >> 4);
    w_beats = 9'(MAX_BURST);
    if (w_room < w_beats) begin
      w_beats = w_room;
    end
    if (i_remaining < 16'(w_beats)) begin
      w_beats = i_remaining[8:0];
    end
  end

  assign o_beats = w_beats;
  assign o_awlen = (w_beats == 9'd0) ? 8'd0 : 8'(w_beats - 9'd1);

endmodule

// File: rtl/axi_pattern_writer.sv
// rtl/axi_pattern_writer.sv - AXI4 write master filling memory with a fixed or address pattern
module axi_pattern_writer
  import axi_pattern_writer_pkg::*;
#(
  parameter int             ADDR_W    = 44,
  parameter int             DATA_W    = 128,
  parameter int             ID_W      = 1,
  parameter int             MAX_BURST = 16,
  parameter logic [127:0]   PATTERN   = PATTERN_DEFAULT
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         num_beats,
  input  logic                pattern_mode,
  input  logic                irq_clear,
  output logic                busy,
  output logic                done_irq,
  output logic                err,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_awaddr;
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]       r_remaining;
  logic [8:0]        r_blen;
  logic [7:0]        r_awlen;
  logic [7:0]        r_beat;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mode;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_wlast;
  logic              r_bready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_out_en;

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_calc_addr;
  logic [15:0]       w_next_rem;
  logic [15:0]       w_calc_rem;
  logic [7:0]        w_awlen;
  logic [8:0]        w_beats;
  logic              w_unused;

  assign w_base      = {base_addr[ADDR_W-1:4], 4'h0};
  assign w_next_addr = r_cur_addr + ADDR_W'({r_blen, 4'h0});
  assign w_next_rem  = r_remaining - 16'(r_blen);
  // The calculator sizes the first burst from the start inputs and every later one from the post-response totals.
  assign w_calc_addr = (r_state == S_IDLE) ? w_base : w_next_addr;
  assign w_calc_rem  = (r_state == S_IDLE) ? num_beats : w_next_rem;
  assign w_unused    = &{1'b0, m_axi_bid, base_addr[3:0]};

  axi_burst_len_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_len (
    .i_addr_lo   (w_calc_addr[11:0]),
    .i_remaining (w_calc_rem),
    .o_awlen     (w_awlen),
    .o_beats     (w_beats)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_awaddr    <= '0;
      r_waddr     <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_awlen     <= '0;
      r_beat      <= '0;
      r_wdata     <= '0;
      r_mode      <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_out_en    <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (irq_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_mode      <= pattern_mode;
            r_cur_addr  <= w_calc_addr;
            r_remaining <= w_calc_rem;
            r_blen      <= w_beats;
            if (num_beats == 16'd0) begin
              r_state <= S_DONE;
            end else begin
              r_awaddr  <= w_calc_addr;
              r_awlen   <= w_awlen;
              r_awvalid <= 1'b1;
              r_state   <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (r_awlen == 8'd0);
            r_beat    <= 8'd0;
            r_wdata   <= beat_data(r_awaddr[31:0], r_mode, PATTERN);
            r_waddr   <= r_awaddr + ADDR_W'(16);
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_axi_wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_wlast <= ((r_beat + 8'd1) == r_awlen);
              r_wdata <= beat_data(r_waddr[31:0], r_mode, PATTERN);
              r_waddr <= r_waddr + ADDR_W'(16);
            end
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            if (m_axi_bresp != RESP_OKAY) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur_addr  <= w_next_addr;
              r_remaining <= w_next_rem;
              r_blen      <= w_beats;
              if (w_next_rem != 16'd0) begin
                r_awaddr  <= w_next_addr;
                r_awlen   <= w_awlen;
                r_awvalid <= 1'b1;
                r_state   <= S_ADDR;
              end else begin
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done_irq      = r_done;
  assign err           = r_err;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = r_out_en ? AXSIZE_16B : 3'b000;
  assign m_axi_awburst = r_out_en ? BURST_INCR : 2'b00;
  assign m_axi_awcache = r_out_en ? AXCACHE_BUF : 4'b0000;
  assign m_axi_awprot  = '0;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_out_en ? '1 : '0;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axi_pattern_writer.sv
// tb/tb_axi_pattern_writer.sv - directed self-checking bench for axi_pattern_writer
`timescale 1ns/1ps
module tb_axi_pattern_writer;

  localparam int ADDR_W = 44;
  localparam int DATA_W = 128;
  localparam int ID_W   = 1;
  localparam logic [127:0] PAT = 128'hDEADBEAF12345678AABBCCDD11223344;

  logic                ACLK = 1'b0;
  logic                ARESETn = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [15:0]         num_beats = '0;
  logic                pattern_mode = 1'b0;
  logic                irq_clear = 1'b0;
  logic                busy, done_irq, err;
  logic [ID_W-1:0]     m_axi_awid;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic [3:0]          m_axi_awcache;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready = 1'b0;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast, m_axi_wvalid;
  logic                m_axi_wready = 1'b0;
  logic [ID_W-1:0]     m_axi_bid = '0;
  logic [1:0]          m_axi_bresp = 2'b00;
  logic                m_axi_bvalid = 1'b0;
  logic                m_axi_bready;

  always #5 ACLK = ~ACLK;

  axi_pattern_writer dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .pattern_mode(pattern_mode), .irq_clear(irq_clear),
    .busy(busy), .done_irq(done_irq), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model state and capture queues
  logic [ADDR_W-1:0] got_awaddr[$];
  logic [7:0]        got_awlen[$];
  logic [127:0]      got_wdata[$];
  logic              got_wlast[$];
  logic [ADDR_W-1:0] exp_awaddr[$];
  logic [7:0]        exp_awlen[$];
  logic [127:0]      exp_wdata[$];
  logic              exp_wlast[$];

  int aw_wait = 0, w_wait = 0, b_wait = 0, b_pending = 0, b_count = 0, err_burst = -1;
  int viol = 0, stall_events = 0, awvalid_seen = 0;
  bit stall_en = 1'b0, b_fire = 1'b0, prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
  logic [ADDR_W-1:0] prev_awaddr;
  logic [7:0]        prev_awlen;
  logic [127:0]      prev_wdata;
  logic              prev_wlast;

  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        b_pending = 0; b_fire = 1'b0; prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
      end else begin
        if (b_fire) begin m_axi_bvalid = 1'b0; b_fire = 1'b0; end
        if (m_axi_awvalid) awvalid_seen++;
        if (prev_aw_stall && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr || m_axi_awlen != prev_awlen)) viol++;
        if (m_axi_awvalid && aw_wait > 0) begin m_axi_awready = 1'b0; aw_wait--; end
        else m_axi_awready = 1'b1;
        prev_aw_stall = m_axi_awvalid && !m_axi_awready;
        if (prev_aw_stall) stall_events++;
        prev_awaddr = m_axi_awaddr; prev_awlen = m_axi_awlen;
        if (m_axi_awvalid && m_axi_awready) begin
          got_awaddr.push_back(m_axi_awaddr); got_awlen.push_back(m_axi_awlen);
          aw_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
        if (prev_w_stall && (!m_axi_wvalid || m_axi_wdata != prev_wdata || m_axi_wlast != prev_wlast)) viol++;
        if (m_axi_wvalid && w_wait > 0) begin m_axi_wready = 1'b0; w_wait--; end
        else m_axi_wready = 1'b1;
        prev_w_stall = m_axi_wvalid && !m_axi_wready;
        if (prev_w_stall) stall_events++;
        prev_wdata = m_axi_wdata; prev_wlast = m_axi_wlast;
        if (m_axi_wvalid && m_axi_wready) begin
          got_wdata.push_back(m_axi_wdata); got_wlast.push_back(m_axi_wlast);
          w_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
          if (m_axi_wlast) begin b_pending++; b_wait = stall_en ? int'($urandom_range(0, 5)) : 0; end
        end
        if (!m_axi_bvalid && b_pending > 0) begin
          if (b_wait > 0) b_wait--;
          else begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
          end
        end
        if (m_axi_bvalid && m_axi_bready) begin b_fire = 1'b1; b_count++; b_pending--; end
      end
    end
  end

  function automatic logic [127:0] lanes(input logic [ADDR_W-1:0] a);
    logic [31:0] b;
    b = a[31:0];
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  task automatic build_model(input logic [ADDR_W-1:0] base, input int n, input bit mode);
    logic [ADDR_W-1:0] a;
    int rem, len, room;
    exp_awaddr.delete(); exp_awlen.delete(); exp_wdata.delete(); exp_wlast.delete();
    a = {base[ADDR_W-1:4], 4'h0};
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 16;
      len = rem;
      if (len > 16) len = 16;
      if (len > room) len = room;
      exp_awaddr.push_back(a); exp_awlen.push_back(8'(len - 1));
      for (int i = 0; i < len; i++) begin
        exp_wdata.push_back(mode ? lanes(a) : PAT);
        exp_wlast.push_back(i == len - 1);
        a = a + ADDR_W'(16);
      end
      rem -= len;
    end
  endtask

  task automatic compare_run(input string tag);
    int bad = 0;
    check({tag, "_bursts"}, 128'(got_awaddr.size()), 128'(exp_awaddr.size()));
    check({tag, "_beats"}, 128'(got_wdata.size()), 128'(exp_wdata.size()));
    for (int i = 0; i < got_awaddr.size() && i < exp_awaddr.size(); i++)
      if (got_awaddr[i] != exp_awaddr[i] || got_awlen[i] != exp_awlen[i]) bad++;
    for (int i = 0; i < got_wdata.size() && i < exp_wdata.size(); i++)
      if (got_wdata[i] != exp_wdata[i] || got_wlast[i] != exp_wlast[i]) bad++;
    check({tag, "_content"}, 128'(bad), 128'(0));
  endtask

  task automatic prep(input bit stall, input int errb);
    got_awaddr.delete(); got_awlen.delete(); got_wdata.delete(); got_wlast.delete();
    stall_en = stall; err_burst = errb; b_count = 0; viol = 0; stall_events = 0; awvalid_seen = 0;
    aw_wait = stall ? 3 : 0; w_wait = stall ? 2 : 0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input int n, input bit mode);
    @(negedge ACLK);
    start = 1'b1; base_addr = base; num_beats = 16'(n); pattern_mode = mode;
    @(negedge ACLK);
    start = 1'b0; pattern_mode = !mode; base_addr = '1; num_beats = 16'd5;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done_irq && cyc < 20000) begin @(negedge ACLK); cyc++; end
    check({tag, "_timeout"}, 128'(cyc < 20000), 128'(1));
  endtask

  task automatic clear_irq();
    @(negedge ACLK); irq_clear = 1'b1;
    @(negedge ACLK); irq_clear = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge ACLK);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done_irq), 128'(0));
    check("rst_awvalid", 128'(m_axi_awvalid), 128'(0));
    check("rst_awaddr_len", 128'({m_axi_awaddr, m_axi_awlen}), 128'(0));
    check("rst_consts", 128'({m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb}), 128'(0));
    check("rst_wdata", m_axi_wdata, 128'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("consts", 128'({m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot}), 128'({3'b100, 2'b01, 4'b0011, 3'b000}));

    // Fixed pattern, 4 beats
    prep(1'b0, -1);
    build_model(44'h0_8000_0000, 4, 1'b0);
    pulse_start(44'h0_8000_0000, 4, 1'b0);
    check("t1_awvalid_lat", 128'({m_axi_awvalid, busy}), 128'(2'b11));
    check("t1_awaddr", 128'(m_axi_awaddr), 128'h8000_0000);
    wait_done("t1");
    check("t1_awlen", 128'(got_awlen[0]), 128'(3));
    check("t1_beat3", got_wdata[3], PAT);
    check("t1_bcount", 128'(b_count), 128'(1));
    check("t1_err", 128'(err), 128'(0));
    compare_run("t1");
    clear_irq();
    check("t1_cleared", 128'(done_irq), 128'(0));

    // Address mode, 512 beats; a start while busy must be dropped
    prep(1'b0, -1);
    build_model(44'h0, 512, 1'b1);
    pulse_start(44'h0, 512, 1'b1);
    repeat (20) @(negedge ACLK);
    start = 1'b1; base_addr = 44'h0_0000_7000; num_beats = 16'd1;
    @(negedge ACLK);
    start = 1'b0;
    wait_done("t2");
    check("t2_bursts", 128'(got_awaddr.size()), 128'(32));
    check("t2_last_awlen", 128'(got_awlen[31]), 128'(15));
    check("t2_beat_0x40", got_wdata[4], 128'h0000004C_00000048_00000044_00000040);
    check("t2_err", 128'(err), 128'(0));
    compare_run("t2");
    clear_irq();

    // 4 KB crossing with irq_clear held: the DONE set must win
    prep(1'b0, -1);
    build_model(44'h0_8000_0FC0, 8, 1'b0);
    irq_clear = 1'b1;
    pulse_start(44'h0_8000_0FC0, 8, 1'b0);
    wait_done("t3");
    check("t3_done_held", 128'(done_irq), 128'(1));
    irq_clear = 1'b0;
    check("t3_aw0", 128'({got_awaddr[0], got_awlen[0]}), 128'({44'h0_8000_0FC0, 8'd3}));
    check("t3_aw1", 128'({got_awaddr[1], got_awlen[1]}), 128'({44'h0_8000_1000, 8'd3}));
    compare_run("t3");
    clear_irq();

    // Random stalls on all channels
    prep(1'b1, -1);
    build_model(44'h0_8000_0F00, 64, 1'b1);
    pulse_start(44'h0_8000_0F00, 64, 1'b1);
    wait_done("t4");
    compare_run("t4");
    check("t4_stable", 128'(viol), 128'(0));
    check("t4_stalled", 128'(stall_events > 0), 128'(1));
    clear_irq();

    // SLVERR on burst 2 of 4
    prep(1'b0, 1);
    pulse_start(44'h0, 64, 1'b0);
    wait_done("t5");
    repeat (5) @(negedge ACLK);
    check("t5_flags", 128'({err, done_irq}), 128'(2'b11));
    check("t5_aw_count", 128'(got_awaddr.size()), 128'(2));
    check("t5_beats", 128'(got_wdata.size()), 128'(32));
    clear_irq();
    check("t5_cleared", 128'({err, done_irq}), 128'(0));

    // num_beats == 0
    prep(1'b0, -1);
    @(negedge ACLK);
    start = 1'b1; num_beats = 16'd0; base_addr = 44'h3000;
    @(negedge ACLK);
    start = 1'b0;
    check("t6_done_c1", 128'(done_irq), 128'(0));
    @(negedge ACLK);
    check("t6_done_c2", 128'(done_irq), 128'(1));
    repeat (3) @(negedge ACLK);
    check("t6_no_aw", 128'(awvalid_seen), 128'(0));
    clear_irq();

    // Reset during DATA, then a normal fill
    prep(1'b1, -1);
    pulse_start(44'h0_0000_2000, 16, 1'b1);
    cyc = 0;
    while (!m_axi_wvalid && cyc < 100) begin @(negedge ACLK); cyc++; end
    check("t7_reach_data", 128'(m_axi_wvalid), 128'(1));
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("t7_rst_valids", 128'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, busy}), 128'(0));
    check("t7_rst_data", m_axi_wdata, 128'(0));
    check("t7_rst_aw", 128'({m_axi_awaddr, m_axi_awlen, m_axi_awsize}), 128'(0));
    ARESETn = 1'b1;
    prep(1'b0, -1);
    build_model(44'h0_0000_2000, 20, 1'b1);
    pulse_start(44'h0_0000_2000, 20, 1'b1);
    wait_done("t7");
    compare_run("t7");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
